muldiv_unit: RTL and testbench

Parametrised multi-cycle multiply/divide engine for the EX stage. It executes MULT/MULTU/DIV/DIVU and returns a {hi,lo} result. It uses a start/busy/ready handshake so the ALU can stall cleanly, and it supports annulment on flush. It generalises the current fixed 32-bit divider hookup with three additions: configurable width, configurable multiply latency, and divide-by-zero reporting.

---
 rtl/muldiv_unit_if.sv | 25 ++
 rtl/muldiv_unit.sv | 166 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// Handshake bundle between the EX-stage ALU and the multi-cycle multiply/divide engine.
// The ALU drives the master modport; the engine implements the slave modport.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic               start_i;
    logic [1:0]         op_i;
    logic [WIDTH-1:0]   a_i;
    logic [WIDTH-1:0]   b_i;
    logic               annul_i;
    logic               busy_o;
    logic               ready_o;
    logic [2*WIDTH-1:0] result_o;
    logic               div_zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, annul_i,
        input  busy_o, ready_o, result_o, div_zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, annul_i,
        output busy_o, ready_o, result_o, div_zero_o
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine. Operates on magnitudes and applies the sign
// fix-up in DONE. Division is restoring shift-subtract, one quotient bit per cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

    state_e               state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [1:0]           op_q, op_d;
    logic                 sign_a_q, sign_a_d;
    logic                 sign_b_q, sign_b_d;
    logic [WIDTH-1:0]     mag_a_q, mag_a_d;
    logic [WIDTH-1:0]     mag_b_q, mag_b_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic                 dz_q, dz_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
    logic                 div_zero_q, div_zero_d;

    logic                 in_sign_a, in_sign_b;
    logic [WIDTH-1:0]     in_mag_a, in_mag_b;
    logic [WIDTH:0]       shifted, diff;
    logic                 op_signed, neg_res, neg_rem;
    logic [WIDTH-1:0]     quo_fix, rem_fix;
    logic [2*WIDTH-1:0]   prod, prod_fix;

    // Only MULT/DIV (op_i[0] == 0) treat operands as signed.
    assign in_sign_a = ~bus.op_i[0] & bus.a_i[WIDTH-1];
    assign in_sign_b = ~bus.op_i[0] & bus.b_i[WIDTH-1];
    assign in_mag_a  = in_sign_a ? -bus.a_i : bus.a_i;
    assign in_mag_b  = in_sign_b ? -bus.b_i : bus.b_i;

    // acc_q holds {remainder, quotient-in-progress}; dividend bits shift out of the low half.
    assign shifted = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff    = shifted - {1'b0, mag_b_q};
    assign prod    = {{WIDTH{1'b0}}, mag_a_q} * {{WIDTH{1'b0}}, mag_b_q};

    assign op_signed = ~op_q[0];
    assign neg_res   = op_signed & (sign_a_q ^ sign_b_q);
    assign neg_rem   = op_signed & sign_a_q;
    assign quo_fix   = neg_res ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix  = neg_res ? -acc_q : acc_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        sign_a_d   = sign_a_q;
        sign_b_d   = sign_b_q;
        mag_a_d    = mag_a_q;
        mag_b_d    = mag_b_q;
        acc_d      = acc_q;
        dz_d       = dz_q;
        result_d   = result_q;
        ready_d    = 1'b0;
        div_zero_d = div_zero_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.annul_i) begin
                    op_d       = bus.op_i;
                    sign_a_d   = in_sign_a;
                    sign_b_d   = in_sign_b;
                    mag_a_d    = in_mag_a;
                    mag_b_d    = in_mag_b;
                    cnt_d      = '0;
                    dz_d       = 1'b0;
                    div_zero_d = 1'b0;
                    acc_d      = {{WIDTH{1'b0}}, in_mag_a};
                    if (!bus.op_i[1]) begin
                        state_d = StMul;
                    end else if (bus.b_i == '0) begin
                        dz_d    = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StDiv;
                    end
                end
            end
            StMul: begin
                if (bus.annul_i) begin
                    state_d = StIdle;
                end else begin
                    acc_d = prod;
                    if (cnt_q == CntW'(MUL_LAT - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDiv: begin
                if (bus.annul_i) begin
                    state_d = StIdle;
                end else begin
                    if (!diff[WIDTH]) begin
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    end
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StDone: begin
                ready_d    = 1'b1;
                div_zero_d = dz_q;
                if (dz_q) begin
                    result_d = '0;
                end else if (op_q[1]) begin
                    result_d = {rem_fix, quo_fix};
                end else begin
                    result_d = prod_fix;
                end
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            op_q       <= '0;
            sign_a_q   <= 1'b0;
            sign_b_q   <= 1'b0;
            mag_a_q    <= '0;
            mag_b_q    <= '0;
            acc_q      <= '0;
            dz_q       <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            sign_a_q   <= sign_a_d;
            sign_b_q   <= sign_b_d;
            mag_a_q    <= mag_a_d;
            mag_b_q    <= mag_b_d;
            acc_q      <= acc_d;
            dz_q       <= dz_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign bus.busy_o     = (state_q != StIdle);
    assign bus.ready_o    = ready_q;
    assign bus.result_o   = result_q;
    assign bus.div_zero_o = div_zero_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: a 32-bit/MUL_LAT=2 instance and a 16-bit/MUL_LAT=1
// instance; issued operations queue expected {result, div_zero, ready cycle}.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0] res;
        logic        dz;
        int          t;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];

    muldiv_unit_if #(.WIDTH(32)) bus32 ();
    muldiv_unit_if #(.WIDTH(16)) bus16 ();

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    muldiv_unit #(.WIDTH(16), .MUL_LAT(1)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every ready_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus32.ready_o) begin
            chk("ready32_expected", 64'(q32.size() != 0), 64'd1);
            if (q32.size() != 0) begin
                e = q32.pop_front();
                chk("result32", bus32.result_o, e.res);
                chk("div_zero32", 64'(bus32.div_zero_o), 64'(e.dz));
                chk("latency32", 64'(cyc), 64'(e.t));
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst && bus16.ready_o) begin
            chk("ready16_expected", 64'(q16.size() != 0), 64'd1);
            if (q16.size() != 0) begin
                e = q16.pop_front();
                chk("result16", 64'(bus16.result_o), e.res);
                chk("div_zero16", 64'(bus16.div_zero_o), 64'(e.dz));
                chk("latency16", 64'(cyc), 64'(e.t));
            end
        end
    end

    task automatic issue(input bit w16, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] res, input bit dz,
                         input int lat, input bit push);
        exp_t e;
        if (w16) begin
            bus16.start_i = 1'b1; bus16.op_i = op; bus16.a_i = a[15:0]; bus16.b_i = b[15:0];
        end else begin
            bus32.start_i = 1'b1; bus32.op_i = op; bus32.a_i = a; bus32.b_i = b;
        end
        @(posedge clk);
        #1;
        // Scramble operands after launch; the engine must have latched them.
        if (w16) begin
            bus16.start_i = 1'b0; bus16.a_i = ~a[15:0]; bus16.b_i = ~b[15:0];
            chk("busy16_launch", 64'(bus16.busy_o), 64'd1);
        end else begin
            bus32.start_i = 1'b0; bus32.a_i = ~a; bus32.b_i = ~b;
            chk("busy32_launch", 64'(bus32.busy_o), 64'd1);
        end
        e.res = res;
        e.dz  = dz;
        e.t   = cyc + lat;
        if (push) begin
            if (w16) q16.push_back(e);
            else     q32.push_back(e);
        end
    endtask

    // Returns in the ready cycle of the last result, so the next issue is back-to-back.
    task automatic drain();
        int n = 0;
        while ((q32.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 64'(q32.size() + q16.size()), 64'd0);
        q32.delete();
        q16.delete();
    endtask

    initial begin
        bus32.start_i = 1'b0; bus32.op_i = '0; bus32.a_i = '0; bus32.b_i = '0;
        bus32.annul_i = 1'b0;
        bus16.start_i = 1'b0; bus16.op_i = '0; bus16.a_i = '0; bus16.b_i = '0;
        bus16.annul_i = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy32", 64'(bus32.busy_o), 64'd0);
        chk("rst_ready32", 64'(bus32.ready_o), 64'd0);
        chk("rst_result32", bus32.result_o, 64'd0);
        chk("rst_dz32", 64'(bus32.div_zero_o), 64'd0);
        chk("rst_busy16", 64'(bus16.busy_o), 64'd0);
        chk("rst_result16", 64'(bus16.result_o), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 32-bit multiplies
        issue(0, 2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 0, 3, 1);
        drain();
        issue(0, 2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, 0, 3, 1);
        drain();
        issue(0, 2'b00, 32'h0000_0003, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 0, 3, 1);
        drain();

        // 32-bit signed divides, all sign combinations of interest
        issue(0, 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 0, 33, 1);
        drain();
        issue(0, 2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD, 0, 33, 1);
        drain();
        issue(0, 2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 0, 33, 1);
        drain();

        // Divide by zero, with annul_i held during DONE (must be ignored)
        issue(0, 2'b11, 32'h1234_5678, 32'h0000_0000, 64'h0, 1, 1, 1);
        bus32.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.annul_i = 1'b0;
        drain();

        // Overflow wrap, then a DIVU whose result must survive an annulled op
        issue(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 0, 33, 1);
        drain();
        chk("dz_cleared", 64'(bus32.div_zero_o), 64'd0);
        issue(0, 2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 0, 33, 1);
        drain();

        issue(0, 2'b10, 32'd50, 32'd5, 64'h0, 0, 33, 0);
        repeat (9) @(posedge clk);
        #1;
        chk("busy_before_annul", 64'(bus32.busy_o), 64'd1);
        bus32.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus32.annul_i = 1'b0;
        chk("busy_after_annul", 64'(bus32.busy_o), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("result_held_annul", bus32.result_o, 64'h0000_0002_0000_000E);
        chk("dz_held_annul", 64'(bus32.div_zero_o), 64'd0);

        // start_i during DIV must be ignored
        issue(0, 2'b10, 32'd1000, 32'd3, 64'h0000_0001_0000_014D, 0, 33, 1);
        repeat (4) @(posedge clk);
        #1;
        bus32.start_i = 1'b1; bus32.op_i = 2'b01; bus32.a_i = 32'd9; bus32.b_i = 32'd9;
        @(posedge clk);
        #1;
        bus32.start_i = 1'b0;
        chk("busy_ignored_start", 64'(bus32.busy_o), 64'd1);
        drain();

        // start_i together with annul_i in IDLE: nothing launches
        @(posedge clk);
        #1;
        bus32.start_i = 1'b1; bus32.annul_i = 1'b1; bus32.op_i = 2'b00;
        @(posedge clk);
        #1;
        bus32.start_i = 1'b0; bus32.annul_i = 1'b0;
        chk("busy_start_annul", 64'(bus32.busy_o), 64'd0);
        repeat (5) @(posedge clk);

        // Reset mid-MUL clears every output
        #1;
        issue(0, 2'b00, 32'd3, 32'd5, 64'h0, 0, 3, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", 64'(bus32.busy_o), 64'd0);
        chk("midrst_ready", 64'(bus32.ready_o), 64'd0);
        chk("midrst_result", bus32.result_o, 64'd0);
        chk("midrst_dz", 64'(bus32.div_zero_o), 64'd0);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        // 16-bit instance, issued back-to-back
        issue(1, 2'b00, 32'h0000_FFFF, 32'h0000_0003, 64'h0000_0000_FFFF_FFFD, 0, 2, 1);
        drain();
        issue(1, 2'b01, 32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, 0, 2, 1);
        drain();
        issue(1, 2'b11, 32'h0000_FFFF, 32'h0000_00FF, 64'h0000_0000_0000_0101, 0, 17, 1);
        drain();
        issue(1, 2'b10, 32'h0000_8000, 32'h0000_0003, 64'h0000_0000_FFFE_D556, 0, 17, 1);
        drain();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
